// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic operand path: element format, feeder
// states and the lane/skew index helpers used by feeder, PE grid and collector.
package systolic_pkg;

  localparam int W = 8;
  localparam logic [W-1:0] FP_ZERO = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_t;

  // Bit offset of lane k inside a packed N*W bus.
  function automatic int lane_lsb(input int k);
    return k * W;
  endfunction

  // Position along the skewed wavefront: lane `lane` at step `s` carries element s-lane.
  function automatic int skew_idx(input int s, input int lane);
    return s - lane;
  endfunction

  function automatic logic in_wave(input int s, input int lane, input int n);
    return (skew_idx(s, lane) >= 0) && (skew_idx(s, lane) < n);
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Host-load / control / array-edge bundle of the systolic feeder.
interface systolic_feeder_if
  import systolic_pkg::*;
#(
  parameter int N = 4
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic            load_valid;
  logic            load_ready;
  logic            load_sel;
  logic [RW-1:0]   load_row;
  logic [N*W-1:0]  load_data;
  logic            start;
  logic            start_err;
  logic            busy;
  logic            done;
  logic [N*W-1:0]  a_out;
  logic [N*W-1:0]  b_out;
  logic            out_valid;

  modport master (
    output load_valid, load_sel, load_row, load_data, start,
    input  load_ready, start_err, busy, done, a_out, b_out, out_valid
  );

  modport slave (
    input  load_valid, load_sel, load_row, load_data, start,
    output load_ready, start_err, busy, done, a_out, b_out, out_valid
  );

endinterface

// File: rtl/systolic_feeder_row_buf.sv
// N x N element store: one full-row write port, one combinational element read per lane.
module sys_row_buf
  import systolic_pkg::*;
#(
  parameter int N = 4,
  localparam int RW = (N > 1) ? $clog2(N) : 1
)(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [RW-1:0]         wr_row,
  input  logic [N*W-1:0]        wr_data,
  input  logic [N-1:0][RW-1:0]  rd_row,
  input  logic [N-1:0][RW-1:0]  rd_col,
  output logic [N*W-1:0]        rd_data
);

  logic [N*W-1:0] mem [N];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N; k++) begin
      rd_data[lane_lsb(k) +: W] = mem[rd_row[k]][lane_lsb(int'(rd_col[k])) +: W];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Systolic-array operand feeder: buffers A and B, streams the skewed wavefront,
// then waits out the PE drain before pulsing done.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int DRAIN = 2*N + 4
)(
  input  logic               clk,
  input  logic               rst,
  systolic_feeder_if.slave   bus
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(2*N);
  localparam int DW = $clog2(DRAIN + 1);
  localparam logic [SW-1:0] LAST_STEP  = SW'(2*N - 2);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN - 1);

  feeder_state_t state, state_nxt;
  logic [SW-1:0] step, step_nxt;
  logic [DW-1:0] drain, drain_nxt;
  logic          drain_end, drain_end_nxt;
  logic [N-1:0]  loaded_a, loaded_b;
  logic          load_fire, masks_full, start_ok;

  logic [N-1:0]           live;
  logic [N-1:0][RW-1:0]   a_row, a_col, b_row, b_col;
  logic [N*W-1:0]         a_rd, b_rd;

  logic [N*W-1:0] a_q, b_q, a_d, b_d;
  logic out_valid_q, busy_q, done_q, start_err_q, load_ready_q;
  logic out_valid_d, busy_d, done_d, start_err_d, load_ready_d;

  assign load_fire  = bus.load_valid && (state == IDLE);
  assign masks_full = (&loaded_a) && (&loaded_b);
  assign start_ok   = bus.start && (state == IDLE) && masks_full;

  sys_row_buf #(.N(N)) u_buf_a (
    .clk     (clk),
    .wr_en   (load_fire && !bus.load_sel),
    .wr_row  (bus.load_row),
    .wr_data (bus.load_data),
    .rd_row  (a_row),
    .rd_col  (a_col),
    .rd_data (a_rd)
  );

  sys_row_buf #(.N(N)) u_buf_b (
    .clk     (clk),
    .wr_en   (load_fire && bus.load_sel),
    .wr_row  (bus.load_row),
    .wr_data (bus.load_data),
    .rd_row  (b_row),
    .rd_col  (b_col),
    .rd_data (b_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      drain     <= '0;
      drain_end <= 1'b0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      drain     <= drain_nxt;
      drain_end <= drain_end_nxt;
    end
  end

  // Masks are cleared on entering FLUSH so each run needs a full reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_a <= '0;
      loaded_b <= '0;
    end else if (state == STREAM && state_nxt == FLUSH) begin
      loaded_a <= '0;
      loaded_b <= '0;
    end else if (load_fire) begin
      if (bus.load_sel) loaded_b[bus.load_row] <= 1'b1;
      else              loaded_a[bus.load_row] <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    step_nxt      = step;
    drain_nxt     = drain;
    drain_end_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = STREAM;
          step_nxt  = '0;
        end
      end
      STREAM: begin
        if (step == LAST_STEP) begin
          state_nxt = FLUSH;
          step_nxt  = '0;
          drain_nxt = '0;
        end else begin
          step_nxt = step + 1'b1;
        end
      end
      FLUSH: begin
        if (drain == LAST_DRAIN) begin
          state_nxt     = IDLE;
          drain_nxt     = '0;
          drain_end_nxt = 1'b1;
        end else begin
          drain_nxt = drain + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A lane i reads A[i][s-i]; B lane j reads B[s-j][j].
  always_comb begin
    for (int k = 0; k < N; k++) begin
      live[k]  = in_wave(int'(step), k, N);
      a_row[k] = RW'(k);
      a_col[k] = RW'(skew_idx(int'(step), k));
      b_row[k] = RW'(skew_idx(int'(step), k));
      b_col[k] = RW'(k);
    end
  end

  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int k = 0; k < N; k++) begin
      a_d[lane_lsb(k) +: W] = (state == STREAM && live[k]) ? a_rd[lane_lsb(k) +: W] : FP_ZERO;
      b_d[lane_lsb(k) +: W] = (state == STREAM && live[k]) ? b_rd[lane_lsb(k) +: W] : FP_ZERO;
    end
    out_valid_d  = (state == STREAM);
    busy_d       = (state != IDLE);
    done_d       = drain_end;
    start_err_d  = bus.start && !start_ok;
    load_ready_d = (state_nxt == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_err_q  <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_err_q  <= start_err_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.start_err  = start_err_q;
  assign bus.load_ready = load_ready_q;

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Transmit side of the systolic-array operand interface. Buffers an N×N A matrix (row-wise) and an N×N B matrix (row-wise), then drives the array's left edge (A rows) and top edge (B columns) with the diagonal-skewed wavefront the PEs expect. Zero is inserted outside the wavefront. After the wavefront, the feeder waits a fixed drain interval so the last partial sums clear the pipelined multiply/add, then flags completion. It sits between the host-side load logic and the PE grid.

## Interface
- N, 4: array dimension; matrices are N×N.
- W, 8: element width; one 8-bit float per element.
- DRAIN, 2*N+4: cycles after the last wavefront step before `done`; covers PE mult/add latency plus grid traversal.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- load_valid  in  1  a row is presented on `load_data`.
- load_ready  out  1  row accepted this cycle when high together with `load_valid`.
- load_sel  in  1  0 = row belongs to A, 1 = row belongs to B.
- load_row  in  $clog2(N)  row index.
- load_data  in  N*W  row elements; element k occupies bits [k*W +: W].
- start  in  1  begin streaming; single-cycle pulse.
- start_err  out  1  one-cycle pulse; `start` was rejected.
- busy  out  1  high in STREAM and FLUSH.
- done  out  1  one-cycle pulse at the end of FLUSH.
- a_out  out  N*W  lane i drives the left edge of array row i.
- b_out  out  N*W  lane j drives the top edge of array column j.
- out_valid  out  1  high while the wavefront steps are on a_out/b_out.

## Operation
- States: IDLE, STREAM, FLUSH.
  - IDLE→STREAM on `start` when all N rows of A and all N rows of B are loaded.
  - STREAM→FLUSH after step 2N-2.
  - FLUSH→IDLE after DRAIN cycles; `done` pulses on that transition.
- Load tracking:
  - Two N-bit masks, loaded_a and loaded_b.
  - A handshake sets the mask bit for `load_row` in the matrix chosen by `load_sel`, and writes the row.
  - Reloading a row in IDLE overwrites it; the mask bit stays set.
- `load_ready` equals (state == IDLE). Loads are never accepted in STREAM or FLUSH.
- `start` is rejected, with a `start_err` pulse and no state change, in either case:
  - state is not IDLE;
  - either mask is not all-ones.
- Load and `start` in the same IDLE cycle: the load is performed. `start` evaluates the masks from before that load.
- Step counter s runs 0..2N-2 during STREAM.
  - a_out lane i = A[i][s-i] if 0 ≤ s-i < N, else 8'h00.
  - b_out lane j = B[s-j][j] if 0 ≤ s-j < N, else 8'h00.
- Entering FLUSH clears both masks, so every run requires a fresh load of both matrices.
- In IDLE and FLUSH, a_out and b_out are 0.
- Reset (asserted in any state, including mid-STREAM):
  - next edge: IDLE, masks cleared, counters 0;
  - a_out = 0, b_out = 0, out_valid = 0, busy = 0, done = 0, start_err = 0;
  - buffer contents are don't-care.

## Timing
- All outputs are registered.
- `start` sampled at edge T: busy and out_valid rise after edge T+1, and step 0 is on a_out/b_out in that same cycle.
- Step s is visible in the cycle after edge T+1+s. out_valid stays high for exactly 2N-1 cycles.
- FLUSH lasts DRAIN cycles. `done` is high in the cycle after the last FLUSH edge, and busy is low in that same cycle.
- Start-to-done latency: 2N-1+DRAIN+1 cycles.
- `start_err` is high in the cycle after the rejected `start` edge.
- Back-to-back runs are allowed: load both matrices, then `start` as early as the first IDLE cycle after `done`.

## Structure
- Package systolic_pkg holds:
  - W and the float zero constant FP_ZERO = 8'h00;
  - the feeder state enum (IDLE, STREAM, FLUSH);
  - the lane-pack/unpack index helpers shared with the PE grid and the result collector.
- One sub-module, sys_row_buf:
  - N×N×W register file with a single row write port;
  - combinational read of element [r][c] per lane;
  - instantiated twice, once for A and once for B.
- The feeder top holds the FSM, masks, step/drain counters, skew index logic and the output registers.

## Test plan
All scenarios use N=4 and DRAIN=12.
- Identity feed: load A = B with A[i][k] = 8'h10+4i+k, then `start` → for s=0..6, lane i of a_out = A[i][s-i] where valid and 0 elsewhere; b_out matches its rule; out_valid high for exactly 7 cycles; `done` 20 cycles after `start`.
- Incomplete load: load A rows 0–3 and B rows 0–2, then `start` → `start_err` pulse, state stays IDLE, out_valid stays 0. Load B row 3, then `start` → streaming begins.
- Start during STREAM: second `start` at step 3 → `start_err` pulse; stream and `done` timing are unchanged.
- Load during busy: `load_valid` held high through STREAM → `load_ready` = 0 and the buffer is unchanged (a rerun after a full reload matches the expected values).
- Reset at step 2: rst high for one cycle → the next cycle has all outputs 0 and state IDLE. `start` without reload → `start_err`.
- Overwrite in IDLE: load A row 1 as 8'hAA×4, then again as 8'h55×4 → streamed A row 1 shows only 8'h55.
